// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control sequencer: Moore-decoded datapath controls, memReady timeout, retire counter.
// Optional: define MC_JUMP_EN to decode opCode 2 (J) through the JUMP state; otherwise it is illegal.

module mc_control_fsm #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [5:0]       opCode,
    input  logic             memReady,
    output logic             pcWrite,
    output logic             pcWriteCond,
    output logic             iorD,
    output logic             memRead,
    output logic             memWrite,
    output logic             memToReg,
    output logic             irWrite,
    output logic             aluSrcA,
    output logic             regWrite,
    output logic             regDst,
    output logic [1:0]       aluOp,
    output logic [1:0]       aluSrcB,
    output logic [1:0]       pcSource,
    output logic [3:0]       state,
    output logic             illegalOp,
    output logic             busError,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE   = 6'd0;
    localparam logic [5:0] OP_LW      = 6'd35;
    localparam logic [5:0] OP_SW      = 6'd43;
    localparam logic [5:0] OP_BEQ     = 6'd4;
`ifdef MC_JUMP_EN
    localparam logic [5:0] OP_J       = 6'd2;
`endif
    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX);

    state_t             state_q, state_d;
    state_t             boundary_state;
    logic [7:0]         wait_q, wait_d;
    logic               bus_error_q, bus_error_d;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               mem_wait;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wait_q      <= 8'd0;
            bus_error_q <= 1'b0;
            illegal_q   <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            bus_error_q <= bus_error_d;
            illegal_q   <= illegal_d;
            retired_q   <= retired_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        wait_d         = wait_q;
        bus_error_d    = bus_error_q;
        illegal_d      = 1'b0;
        retired_d      = retired_q;
        mem_wait       = 1'b0;
        boundary_state = run ? S_FETCH : S_IDLE;

        case (state_q)
            S_IDLE: begin
                if (run && !bus_error_q) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_wait = 1'b1;
                if (memReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opCode)
                    OP_RTYPE:      state_d = S_EXECUTE;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ:        state_d = S_BRANCH;
`ifdef MC_JUMP_EN
                    OP_J:          state_d = S_JUMP;
`endif
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                state_d = (opCode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_wait = 1'b1;
                if (memReady) state_d = S_MEM_WB;
            end
            S_MEM_WRITE: begin
                mem_wait = 1'b1;
                if (memReady) begin
                    state_d   = S_FETCH;
                    retired_d = retired_q + CNT_W'(1);
                end
            end
            S_EXECUTE: state_d = S_R_WB;
            S_MEM_WB, S_R_WB, S_BRANCH: begin
                state_d   = boundary_state;
                retired_d = retired_q + CNT_W'(1);
            end
`ifdef MC_JUMP_EN
            S_JUMP: begin
                state_d   = boundary_state;
                retired_d = retired_q + CNT_W'(1);
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // A stuck memory aborts the instruction; a late memReady on the limit cycle still wins.
        if (mem_wait && !memReady) begin
            if (wait_q == WAIT_LIMIT) begin
                bus_error_d = 1'b1;
                state_d     = S_IDLE;
            end else begin
                wait_d = wait_q + 8'd1;
            end
        end

        if ((state_d != state_q) &&
            (state_d == S_FETCH || state_d == S_MEM_READ || state_d == S_MEM_WRITE)) begin
            wait_d = 8'd0;
        end
    end

    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        memToReg    = 1'b0;
        irWrite     = 1'b0;
        aluSrcA     = 1'b0;
        regWrite    = 1'b0;
        regDst      = 1'b0;
        aluOp       = 2'b00;
        aluSrcB     = 2'b00;
        pcSource    = 2'b00;

        case (state_q)
            S_FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'b01;
                irWrite = memReady;
                pcWrite = memReady;
            end
            S_DECODE:   aluSrcB = 2'b11;
            S_MEM_ADDR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            S_MEM_READ: begin
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            S_MEM_WB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
            end
            S_MEM_WRITE: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
            end
            S_EXECUTE: begin
                aluSrcA = 1'b1;
                aluOp   = 2'b10;
            end
            S_R_WB: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA     = 1'b1;
                aluOp       = 2'b01;
                pcWriteCond = 1'b1;
                pcSource    = 2'b01;
            end
            S_JUMP: begin
                pcWrite  = 1'b1;
                pcSource = 2'b10;
            end
            default: ;
        endcase
    end

    assign state     = state_q;
    assign illegalOp = illegal_q;
    assign busError  = bus_error_q;
    assign retired   = retired_q;

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle sequencer for the single-datapath MIPS core: one shared ALU, one shared memory port, instruction register, PC.
- Decodes opCode, then steps the datapath through fetch/decode/execute/memory/writeback, one micro-state per clock.
- Waits on a memory-ready handshake, times out on a stuck memory and counts retired instructions.
- Sits between the IR opcode field and every datapath mux/write-enable.

Parameters:
- MEM_WAIT_MAX, 15: maximum consecutive cycles a memory state may wait for memReady before bus error (1..255).
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  level; allows IDLE->FETCH
- opCode  in  6  IR[31:26]; sampled in DECODE
- memReady  in  1  memory completes current access this cycle
- pcWrite, pcWriteCond, iorD, memRead, memWrite, memToReg, irWrite, aluSrcA, regWrite, regDst  out  1 each  datapath controls
- aluOp, aluSrcB, pcSource  out  2 each  datapath mux selects
- state  out  4  current state code (debug)
- illegalOp  out  1  one-cycle pulse, unsupported opcode
- busError  out  1  sticky memory timeout flag
- retired  out  CNT_W  retired-instruction count

Behaviour:
- Clock and reset: one clock (clk). rst_n is asynchronous and active-low. Reset forces state=IDLE, wait counter=0, retired=0, busError=0, illegalOp=0.
- Control outputs are Moore-decoded from state. The only exceptions are irWrite/pcWrite in FETCH, which are gated by memReady. All controls read 0 in IDLE.
- State codes: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXECUTE=7, R_WB=8, BRANCH=9, JUMP=10. Codes 11-15 are unreachable and go to IDLE.
- Per-state outputs (unlisted outputs are 0):
  - FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00; irWrite=pcWrite=memReady.
  - DECODE: aluSrcA=0, aluSrcB=11, aluOp=00.
  - MEM_ADDR: aluSrcA=1, aluSrcB=10, aluOp=00.
  - MEM_READ: memRead=1, iorD=1.
  - MEM_WB: regWrite=1, memToReg=1, regDst=0.
  - MEM_WRITE: memWrite=1, iorD=1.
  - EXECUTE: aluSrcA=1, aluSrcB=00, aluOp=10.
  - R_WB: regWrite=1, regDst=1.
  - BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01.
  - JUMP: pcWrite=1, pcSource=10.
- Transitions:
  - IDLE->FETCH when run=1 and busError=0; otherwise stay.
  - FETCH->DECODE on memReady.
  - DECODE on opCode: 0->EXECUTE, 35 or 43->MEM_ADDR, 4->BRANCH, other->FETCH with illegalOp=1 for the next cycle.
  - MEM_ADDR->MEM_READ if opCode=35, else MEM_WRITE.
  - MEM_READ->MEM_WB on memReady.
  - MEM_WRITE->FETCH on memReady.
  - EXECUTE->R_WB.
  - MEM_WB, R_WB and BRANCH -> FETCH, or IDLE if run=0.
- Wait counter: 8-bit.
  - Cleared on entry to FETCH, MEM_READ or MEM_WRITE.
  - Increments on each cycle in those states with memReady=0.
  - When it equals MEM_WAIT_MAX and memReady=0: busError<=1 and state<=IDLE. Memory strobes drop the next cycle.
  - memReady in the same cycle the counter reaches the limit: the access completes and no error is raised.
- busError stays 1 until rst_n; IDLE does not leave while busError=1.
- retired increments by 1 on the exit edge of MEM_WB, MEM_WRITE (with memReady), R_WB, BRANCH and JUMP. It wraps modulo 2^CNT_W. Illegal opcodes do not count.
- run=0 mid-instruction takes effect only at an instruction boundary; the instruction always completes.
- Reset mid-instruction aborts immediately; no partial write strobe follows.

Optional Feature:
- Macro MC_JUMP_EN.
- Defined: DECODE with opCode=2 -> JUMP; JUMP -> FETCH (or IDLE if run=0); counts as retired.
- Undefined: opCode=2 is treated as illegal (illegalOp pulse, return to FETCH); the JUMP state is never entered.

Test Plan:
- Reset, run=1, memReady=1, opCode=0 -> states 1,2,7,8,1; regWrite=regDst=1 in R_WB; retired=1 after 4 cycles.
- opCode=35, memReady low 3 cycles in MEM_READ -> MEM_READ held 4 cycles with memRead=iorD=1; MEM_WB asserts regWrite=memToReg=1; retired=1.
- opCode=43, memReady stuck 0 in MEM_WRITE, MEM_WAIT_MAX=15 -> after 15 wait cycles busError=1, state=0, memWrite=0; run stays ignored until rst_n.
- opCode=4 -> BRANCH with pcWriteCond=1, aluOp=01, pcSource=01; opCode=63 -> illegalOp single-cycle pulse, state returns to 1, retired unchanged.
- CNT_W=4, 16 back-to-back R-type instructions -> retired wraps to 0. Assert rst_n=0 during MEM_WRITE -> memWrite drops asynchronously, state=0.
- opCode=2 with MC_JUMP_EN -> state 10, pcWrite=1, pcSource=10; without the macro -> illegalOp=1, no pcWrite.
